// File: rtl/hilo_mul_unit.sv
// Iterative radix-2 multiply/accumulate unit owning the MIPS HI/LO register pair.
// Latency WIDTH+1 cycles from Start to Done; Busy stalls issue, Start ignored while Busy.
module hilo_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic [1:0]           op_q;
  logic [CW-1:0]        cnt;

  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   hilo;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [2*WIDTH-1:0]   acc_next;

  // Signed ops multiply magnitudes and restore the sign in FIX; MULTU passes raw operands.
  always_comb begin
    signed_op = (Op != 3'b001);
    a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
    b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
    hilo      = {Hi, Lo};
    prod_fix  = neg ? -prod : prod;
    case (op_q)
      2'b10:   acc_next = hilo + prod_fix;
      2'b11:   acc_next = hilo - prod_fix;
      default: acc_next = prod_fix;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      op_q   <= 2'b00;
      cnt    <= '0;
      Hi     <= '0;
      Lo     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          // A flush arriving with a request cancels the request outright.
          if (Start && !Abort) begin
            if (!Op[2]) begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              neg    <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
              op_q   <= Op[1:0];
              prod   <= '0;
              cnt    <= '0;
              Busy   <= 1'b1;
              state  <= RUN;
            end else if (Op[1:0] == 2'b00) begin
              Hi <= A;
            end else if (Op[1:0] == 2'b01) begin
              Lo <= A;
            end
          end
        end
        RUN: begin
          if (Abort) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (!Abort) begin
            {Hi, Lo} <= acc_next;
            Done     <= 1'b1;
          end
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Bench for hilo_mul_unit: vector table with scoreboard queue, plus hand-written
// sequences for busy-ignore, back-to-back, abort, async reset and random ops.
module tb_hilo_mul_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'b000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Abort = 1'b0;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];
  logic [63:0] model;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[13];

  hilo_mul_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Abort(Abort), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the start edge; waits for Done and checks it.
  task automatic wait_done(input string name, input int exp_lat);
    int cycles = 0;
    logic [63:0] e;
    while (!Done && cycles < 100) begin
      @(negedge Clk);
      cycles++;
    end
    if (!Done) begin
      check({name, " done timeout"}, 64'(cycles), 64'(exp_lat));
    end else begin
      check({name, " latency"}, 64'(cycles), 64'(exp_lat));
      check({name, " busy at done"}, 64'(Busy), 64'd0);
      if (sb.size() == 0) begin
        check({name, " scoreboard empty"}, 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({name, " hilo"}, {Hi, Lo}, e);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    if (!op[2]) sb.push_back(exp);
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    if (!op[2]) begin
      check({name, " busy"}, 64'(Busy), 64'd1);
      wait_done(name, LAT);
    end else begin
      check({name, " idle"}, {62'd0, Busy, Done}, 64'd0);
      check({name, " hilo"}, {Hi, Lo}, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea, eb;
    if (op == 3'b001) begin
      ea = {32'd0, a}; eb = {32'd0, b};
    end else begin
      ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b};
    end
    return ea * eb;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    logic [63:0] held;

    vecs[0]  = '{3'b000, 32'd7,        32'd6,        64'h00000000_0000002A};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[3]  = '{3'b100, 32'd0,        32'd0,        64'h00000000_00000001};
    vecs[4]  = '{3'b101, 32'd10,       32'd0,        64'h00000000_0000000A};
    vecs[5]  = '{3'b010, 32'd2,        32'd3,        64'h00000000_00000010};
    vecs[6]  = '{3'b011, 32'd4,        32'd5,        64'hFFFFFFFF_FFFFFFFC};
    vecs[7]  = '{3'b000, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[8]  = '{3'b000, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
    vecs[9]  = '{3'b001, 32'h80000000, 32'd2,        64'h00000001_00000000};
    vecs[10] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000001_00000001};
    vecs[11] = '{3'b011, 32'd1,        32'd1,        64'h00000001_00000000};
    vecs[12] = '{3'b110, 32'hDEADBEEF, 32'd1,        64'h00000001_00000000};

    #12;
    check("reset hilo", {Hi, Lo}, 64'd0);
    check("reset busy/done", {62'd0, Busy, Done}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Start while busy is ignored; a start on the Done cycle is accepted.
    @(negedge Clk);
    Start = 1'b1; Op = 3'b000; A = 32'd9; B = 32'd9;
    sb.push_back(64'd81);
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    Start = 1'b1; A = 32'd2; B = 32'd2;
    @(negedge Clk);
    Start = 1'b0;
    wait_done("busy ignore", LAT - 6);
    Start = 1'b1; Op = 3'b000; A = 32'd2; B = 32'd2;
    sb.push_back(64'd4);
    @(negedge Clk);
    Start = 1'b0;
    check("b2b busy", 64'(Busy), 64'd1);
    wait_done("b2b", LAT);

    // Asynchronous reset in the middle of a multiply.
    @(negedge Clk);
    Start = 1'b1; Op = 3'b000; A = 32'd7; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("async rst hilo", {Hi, Lo}, 64'd0);
    check("async rst busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Abort mid-MADD discards the accumulation.
    run_op("mthi", 3'b100, 32'h1234, 32'd0, 64'h00001234_00000000);
    run_op("mtlo", 3'b101, 32'h5678, 32'd0, 64'h00001234_00005678);
    @(negedge Clk);
    Start = 1'b1; Op = 3'b010; A = 32'd3; B = 32'd4;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("abort busy", 64'(Busy), 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (Done) saw_done = 1'b1;
      @(negedge Clk);
    end
    check("abort no done", 64'(saw_done), 64'd0);
    check("abort hilo", {Hi, Lo}, 64'h00001234_00005678);

    // Abort and Start together in IDLE: nothing starts.
    Start = 1'b1; Abort = 1'b1; Op = 3'b000; A = 32'd5; B = 32'd5;
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
    check("abort+start busy", 64'(Busy), 64'd0);
    repeat (40) @(negedge Clk);
    check("abort+start hilo", {Hi, Lo}, 64'h00001234_00005678);
    run_op("madd after abort", 3'b010, 32'd1, 32'd1, 64'h00001234_00005679);

    // Random ops against a 64-bit arithmetic model.
    model = 64'h00001234_00005679;
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      if (i == 0) a = 32'd0;
      case (op)
        3'b010:  model = model + ref_prod(op, a, b);
        3'b011:  model = model - ref_prod(op, a, b);
        default: model = ref_prod(op, a, b);
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, model);
    end

    held = {Hi, Lo};
    repeat (3) @(negedge Clk);
    check("hilo stable idle", {Hi, Lo}, held);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
